lvds_timing_gen: RTL

LVDS_TIMING_GEN -- requirements
Module: lvds_timing_gen

---
 rtl/lvds_video_pkg.sv | 22 ++
 rtl/timing_axis.sv | 45 ++++
 rtl/lvds_timing_gen.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/lvds_video_pkg.sv
// Shared timing defaults, counter width and FSM encoding for the LVDS video timing generator.
package lvds_video_pkg;

  localparam int unsigned CNT_W   = 12;
  localparam int unsigned MAX_TOT = 4096;

  localparam int unsigned H_ACTIVE_DEF = 1024;
  localparam int unsigned H_FP_DEF     = 160;
  localparam int unsigned H_SYNC_DEF   = 20;
  localparam int unsigned H_BP_DEF     = 140;

  localparam int unsigned V_ACTIVE_DEF = 600;
  localparam int unsigned V_FP_DEF     = 12;
  localparam int unsigned V_SYNC_DEF   = 3;
  localparam int unsigned V_BP_DEF     = 20;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/timing_axis.sv
// One timing axis: wrapping counter plus look-ahead active and sync-window flags
// for the value the counter will hold after the next edge.
module timing_axis
  import lvds_video_pkg::*;
#(
  parameter int unsigned TOTAL      = 1344,
  parameter int unsigned ACTIVE     = 1024,
  parameter int unsigned SYNC_START = 1184,
  parameter int unsigned SYNC_END   = 1204
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt_c,
  output logic             active_nxt_c,
  output logic             sync_nxt_c,
  output logic             last_c
);

  assign last_c = (32'(cnt) == TOTAL - 1);

  // Next count: clear wins, otherwise advance with wrap at TOTAL-1.
  always_comb begin
    cnt_nxt_c = cnt;
    if (clr) begin
      cnt_nxt_c = '0;
    end else if (inc) begin
      cnt_nxt_c = last_c ? '0 : cnt + CNT_W'(1);
    end
  end

  assign active_nxt_c = (32'(cnt_nxt_c) < ACTIVE);
  assign sync_nxt_c   = (32'(cnt_nxt_c) >= SYNC_START) && (32'(cnt_nxt_c) < SYNC_END);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt_c;
    end
  end

endmodule

// File: rtl/lvds_timing_gen.sv
// LVDS panel timing generator: h/v counters, de, syncs and start pulses,
// all registered so every output in a cycle describes the same pixel.
module lvds_timing_gen
  import lvds_video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             de,
  output logic             hsync,
  output logic             vsync,
  output logic             line_start,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > MAX_TOT) begin : g_bad_h_total
    $error("lvds_timing_gen: H_TOTAL exceeds 4096");
  end
  if (V_TOTAL > MAX_TOT) begin : g_bad_v_total
    $error("lvds_timing_gen: V_TOTAL exceeds 4096");
  end

  state_t state_q;
  state_t state_nxt;

  logic             keep_c;
  logic             h_last_c;
  logic             v_last_c;
  logic             h_act_c;
  logic             v_act_c;
  logic             h_sync_c;
  logic             v_sync_c;
  logic [CNT_W-1:0] h_nxt_c;
  logic [CNT_W-1:0] v_nxt_c;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;

  logic de_nxt;
  logic hsync_nxt;
  logic vsync_nxt;
  logic line_start_nxt;
  logic frame_start_nxt;

  // Counters only advance while running and staying in RUN; any other move parks them at 0.
  assign keep_c = (state_q == ST_RUN) && (state_nxt == ST_RUN);

  timing_axis #(
    .TOTAL      (H_TOTAL),
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (H_ACTIVE + H_FP),
    .SYNC_END   (H_ACTIVE + H_FP + H_SYNC)
  ) u_h_axis (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (!keep_c),
    .inc          (keep_c),
    .cnt          (h_cnt),
    .cnt_nxt_c    (h_nxt_c),
    .active_nxt_c (h_act_c),
    .sync_nxt_c   (h_sync_c),
    .last_c       (h_last_c)
  );

  timing_axis #(
    .TOTAL      (V_TOTAL),
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (V_ACTIVE + V_FP),
    .SYNC_END   (V_ACTIVE + V_FP + V_SYNC)
  ) u_v_axis (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (!keep_c),
    .inc          (keep_c && h_last_c),
    .cnt          (v_cnt),
    .cnt_nxt_c    (v_nxt_c),
    .active_nxt_c (v_act_c),
    .sync_nxt_c   (v_sync_c),
    .last_c       (v_last_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // en is only consulted at the last pixel, so dropping and re-raising it mid-frame is invisible.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: if (en) state_nxt = ST_RUN;
      ST_RUN:  if (h_last_c && v_last_c && !en) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    de_nxt          = 1'b0;
    hsync_nxt       = ~HS_POL;
    vsync_nxt       = ~VS_POL;
    line_start_nxt  = 1'b0;
    frame_start_nxt = 1'b0;
    if (state_nxt == ST_RUN) begin
      de_nxt          = h_act_c && v_act_c;
      hsync_nxt       = h_sync_c ? HS_POL : ~HS_POL;
      vsync_nxt       = v_sync_c ? VS_POL : ~VS_POL;
      line_start_nxt  = (h_nxt_c == '0);
      frame_start_nxt = (h_nxt_c == '0) && (v_nxt_c == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      de          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      de          <= de_nxt;
      hsync       <= hsync_nxt;
      vsync       <= vsync_nxt;
      line_start  <= line_start_nxt;
      frame_start <= frame_start_nxt;
    end
  end

  assign x = h_cnt;
  assign y = v_cnt;

endmodule
